// File: rtl/move_resolver_if.sv
// Request/result handshake bundle between the battle controller and move_resolver.
// The slave modport is the resolver side; master is the controller/consumer side.
interface move_resolver_if;
  logic       req;
  logic [1:0] move_sel;
  logic       attacker;
  logic       ready;
  logic       res_valid;
  logic       res_ack;
  logic       res_hit;
  logic [3:0] res_dmg;
  logic [3:0] res_accu;
  logic [3:0] res_roll;
  logic       res_target;
  logic       res_crit;

  modport master (
    output req, move_sel, attacker, res_ack,
    input  ready, res_valid, res_hit, res_dmg, res_accu, res_roll, res_target, res_crit
  );

  modport slave (
    input  req, move_sel, attacker, res_ack,
    output ready, res_valid, res_hit, res_dmg, res_accu, res_roll, res_target, res_crit
  );
endinterface

// File: rtl/move_resolver.sv
// Resolves one attack: latches move/attacker, rolls accuracy from a free-running Galois LFSR,
// and returns hit/damage over a valid/ack handshake. Optional critical hits: CRIT_HIT_EN.
module move_resolver #(
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [31:0] MOVE_TABLE = 32'hF4B65900
) (
  input logic            clk,
  input logic            reset_n,
  move_resolver_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRoll, StResolve, StDone} state_e;

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [7:0] SeedInit = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_e     state_q, state_d;
  logic [7:0] lfsr_q;
  logic [1:0] move_q;
  logic       attacker_q;
  logic [3:0] roll_q, accu_q, dmg_q;
  logic [7:0] entry;
  logic       hit;
  logic [3:0] dmg_eff;

  logic       res_hit_q, res_target_q;
  logic [3:0] res_dmg_q, res_accu_q, res_roll_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SeedInit;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.req) state_d = StRoll;
      StRoll:    state_d = StResolve;
      StResolve: state_d = StDone;
      StDone:    if (bus.res_ack) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign entry = MOVE_TABLE[{move_q, 3'b000} +: 8];

`ifdef CRIT_HIT_EN
  logic [3:0] hi_q;
  logic       crit;
  logic [4:0] dmg_x2;
  logic       res_crit_q;

  always_comb begin
    hit    = (roll_q <= accu_q);
    crit   = hit & (hi_q == 4'hF);
    dmg_x2 = {dmg_q, 1'b0};
    if (crit) begin
      dmg_eff = dmg_x2[4] ? 4'hF : dmg_x2[3:0];
    end else begin
      dmg_eff = hit ? dmg_q : 4'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q       <= 4'h0;
      res_crit_q <= 1'b0;
    end else begin
      if (state_q == StRoll)    hi_q       <= lfsr_q[7:4];
      if (state_q == StResolve) res_crit_q <= crit;
    end
  end

  assign bus.res_crit = res_crit_q;
`else
  always_comb begin
    hit     = (roll_q <= accu_q);
    dmg_eff = hit ? dmg_q : 4'h0;
  end

  assign bus.res_crit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      move_q       <= 2'd0;
      attacker_q   <= 1'b0;
      roll_q       <= 4'h0;
      accu_q       <= 4'h0;
      dmg_q        <= 4'h0;
      res_hit_q    <= 1'b0;
      res_dmg_q    <= 4'h0;
      res_accu_q   <= 4'h0;
      res_roll_q   <= 4'h0;
      res_target_q <= 1'b0;
    end else begin
      if (state_q == StIdle && bus.req) begin
        move_q     <= bus.move_sel;
        attacker_q <= bus.attacker;
      end
      if (state_q == StRoll) begin
        roll_q <= lfsr_q[3:0];
        accu_q <= entry[7:4];
        dmg_q  <= entry[3:0];
      end
      // Result fields persist after the ack until the next resolution overwrites them.
      if (state_q == StResolve) begin
        res_hit_q    <= hit;
        res_dmg_q    <= dmg_eff;
        res_accu_q   <= accu_q;
        res_roll_q   <= roll_q;
        res_target_q <= ~attacker_q;
      end
    end
  end

  assign bus.ready      = (state_q == StIdle);
  assign bus.res_valid  = (state_q == StDone);
  assign bus.res_hit    = res_hit_q;
  assign bus.res_dmg    = res_dmg_q;
  assign bus.res_accu   = res_accu_q;
  assign bus.res_roll   = res_roll_q;
  assign bus.res_target = res_target_q;

endmodule

// File: tb/tb_move_resolver.sv
// Self-checking bench for move_resolver: random requests against a behavioural model of the
// LFSR roll, move table and hit/damage rules. Honours CRIT_HIT_EN in the model.
module tb_move_resolver;

  typedef struct packed {
    logic       hit;
    logic [3:0] dmg;
    logic [3:0] accu;
    logic [3:0] roll;
    logic       target;
    logic       crit;
  } result_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   edge_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  int accu_tab[4] = '{0, 5, 11, 15};
  int dmg_tab[4]  = '{0, 9, 6, 4};

  move_resolver_if bus ();

  move_resolver dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; the LFSR has stepped exactly this many times.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [7:0] lfsr_at(input int n);
    int x;
    x = 'hA5;
    for (int i = 0; i < n; i++) begin
      if (x % 2 == 1) x = (x / 2) ^ 'hB8;
      else            x = x / 2;
    end
    return 8'(x);
  endfunction

  task automatic model(input logic [1:0] mv, input logic att, input int n_acc,
                       output result_t r);
    int l, d;
    l        = int'(lfsr_at(n_acc));
    r.roll   = 4'(l % 16);
    r.accu   = 4'(accu_tab[mv]);
    r.hit    = (int'(r.roll) <= accu_tab[mv]);
    r.target = !att;
    r.crit   = 1'b0;
    d        = r.hit ? dmg_tab[mv] : 0;
`ifdef CRIT_HIT_EN
    if (r.hit && (l / 16 == 15)) begin
      r.crit = 1'b1;
      d      = 2 * dmg_tab[mv];
      if (d > 15) d = 15;
    end
`endif
    r.dmg = 4'(d);
  endtask

  function automatic result_t sample();
    result_t r;
    r.hit    = bus.res_hit;
    r.dmg    = bus.res_dmg;
    r.accu   = bus.res_accu;
    r.roll   = bus.res_roll;
    r.target = bus.res_target;
    r.crit   = bus.res_crit;
    return r;
  endfunction

  // Presents one request (caller guarantees IDLE), then scrambles the inputs.
  task automatic issue(input logic [1:0] mv, input logic att, output int n_acc);
    @(negedge clk);
    bus.req      = 1'b1;
    bus.move_sel = mv;
    bus.attacker = att;
    @(posedge clk);
    #1 n_acc = edge_cnt;
    @(negedge clk);
    bus.req      = 1'b0;
    bus.move_sel = 2'($urandom);
    bus.attacker = 1'($urandom);
  endtask

  // lat = index (relative to accept edge) of the first edge that sees res_valid=1; -1 on timeout.
  task automatic wait_valid(input int n_acc, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin
        lat = edge_cnt - n_acc + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack(input int delay);
    repeat (delay) @(negedge clk);
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.move_sel = 2'd0; bus.attacker = 1'b0; bus.res_ack = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
    n_cmp++;
    if (bus.res_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid);
    end
    n_cmp++;
    if (sample() !== '0) begin
      n_err++; $display("FAIL reset_fields: got %h expected 0", sample());
    end
  endtask

  task automatic test_move3();
    int n_acc, lat;
    result_t got, exp;
    issue(2'd3, 1'b0, n_acc);
    wait_valid(n_acc, lat);
    n_cmp++;
    if (lat !== 3) begin
      n_err++; $display("FAIL move3_latency: got %0d expected 3", lat);
    end
    got = sample();
    model(2'd3, 1'b0, n_acc, exp);
    n_cmp++;
    if (got.hit !== 1'b1 || got.accu !== 4'd15 || got.target !== 1'b1) begin
      n_err++; $display("FAIL move3_hit_accu_target: got %b/%0d/%b expected 1/15/1",
                        got.hit, got.accu, got.target);
    end
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL move3_fields: got %h expected %h", got, exp);
    end
    ack(0);
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.ready !== 1'b1) begin
      n_err++; $display("FAIL move3_after_ack: got valid=%b ready=%b expected 0/1",
                        bus.res_valid, bus.ready);
    end
    n_cmp++;
    if (sample() !== got) begin
      n_err++; $display("FAIL move3_held: got %h expected %h", sample(), got);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, lat;
    result_t got, exp;
    for (int i = 0; i < 8; i++) begin
      issue(2'(i), 1'(i), n_acc);
      wait_valid(n_acc, lat);
      got = sample();
      model(2'(i), 1'(i), n_acc, exp);
      n_cmp++;
      if (lat !== 3 || got !== exp) begin
        n_err++; $display("FAIL b2b_%0d: got lat=%0d %h expected lat=3 %h", i, lat, got, exp);
      end
      ack(0);
    end
  endtask

  task automatic test_random_move1();
    int n_acc, lat, hits;
    logic att;
    result_t got, exp;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      att = 1'($urandom);
      issue(2'd1, att, n_acc);
      wait_valid(n_acc, lat);
      n_cmp++;
      if (lat !== 3) begin
        n_err++; $display("FAIL rand_latency_%0d: got %0d expected 3", i, lat);
        continue;
      end
      got = sample();
      model(2'd1, att, n_acc, exp);
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL rand_fields_%0d: got %h expected %h", i, got, exp);
      end
      if (got.hit) hits++;
      ack($urandom_range(0, 2));
    end
    n_cmp++;
    if (hits < 40 || hits > 120) begin
      n_err++; $display("FAIL rand_hit_rate: got %0d hits expected 40..120 of 200", hits);
    end
  endtask

  task automatic test_hold();
    int n_acc, lat;
    result_t held, got, exp;
    issue(2'd2, 1'b1, n_acc);
    wait_valid(n_acc, lat);
    held = sample();
    for (int i = 0; i < 10; i++) begin
      bus.req      = 1'(i % 2);
      bus.move_sel = 2'($urandom);
      @(negedge clk);
      n_cmp++;
      if (bus.res_valid !== 1'b1 || bus.ready !== 1'b0 || sample() !== held) begin
        n_err++; $display("FAIL hold_%0d: got valid=%b ready=%b %h expected 1/0 %h",
                          i, bus.res_valid, bus.ready, sample(), held);
      end
    end
    // Ack with req high: only the ack may take effect on this edge.
    bus.res_ack = 1'b1; bus.req = 1'b1; bus.move_sel = 2'd2; bus.attacker = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_ack_only: got ready=%b valid=%b expected 1/0",
                        bus.ready, bus.res_valid);
    end
    @(negedge clk);
    bus.res_ack = 1'b0;
    @(posedge clk);
    #1 n_acc = edge_cnt;
    @(negedge clk);
    bus.req = 1'b0;
    wait_valid(n_acc, lat);
    got = sample();
    model(2'd2, 1'b0, n_acc, exp);
    n_cmp++;
    if (lat !== 3 || got !== exp) begin
      n_err++; $display("FAIL hold_next_req: got lat=%0d %h expected lat=3 %h", lat, got, exp);
    end
    ack(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_err++; $display("FAIL hold_single_accept_%0d: got ready=%b valid=%b expected 1/0",
                          i, bus.ready, bus.res_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_acc, lat;
    result_t got, exp;
    @(negedge clk);
    bus.req = 1'b1; bus.move_sel = 2'd2; bus.attacker = 1'b0;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.res_valid !== 1'b0 || sample() !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs: got ready=%b valid=%b %h expected 1/0 0",
                        bus.ready, bus.res_valid, sample());
    end
    @(negedge clk);
    reset_n = 1'b1;
    issue(2'd0, 1'b1, n_acc);
    wait_valid(n_acc, lat);
    got = sample();
    model(2'd0, 1'b1, n_acc, exp);
    n_cmp++;
    if (lat !== 3 || got !== exp) begin
      n_err++; $display("FAIL mid_reset_restart: got lat=%0d %h expected lat=3 %h", lat, got, exp);
    end
    n_cmp++;
    if (got.hit !== (got.roll == 4'd0) || got.dmg !== 4'd0) begin
      n_err++; $display("FAIL mid_reset_move0: got hit=%b dmg=%0d roll=%0d expected hit=(roll==0) dmg=0",
                        got.hit, got.dmg, got.roll);
    end
    ack(0);
  endtask

  task automatic test_crit();
    int n_acc, lat, tries;
    logic [7:0] l;
    result_t got;
    tries = 0;
    // issue() accepts two edges from now, so aim the roll at that LFSR state.
    l = lfsr_at(edge_cnt + 2);
    while (!(l[7:4] == 4'hF && l[3:0] <= 4'd5) && tries < 600) begin
      @(negedge clk);
      tries++;
      l = lfsr_at(edge_cnt + 2);
    end
    n_cmp++;
    if (tries >= 600) begin
      n_err++; $display("FAIL crit_search: got no crit window expected one within 600 cycles");
      return;
    end
    issue(2'd1, 1'b0, n_acc);
    wait_valid(n_acc, lat);
    got = sample();
    n_cmp++;
`ifdef CRIT_HIT_EN
    if (lat !== 3 || got.hit !== 1'b1 || got.crit !== 1'b1 || got.dmg !== 4'd15) begin
      n_err++; $display("FAIL crit_on: got lat=%0d hit=%b crit=%b dmg=%0d expected 3/1/1/15",
                        lat, got.hit, got.crit, got.dmg);
    end
`else
    if (lat !== 3 || got.hit !== 1'b1 || got.crit !== 1'b0 || got.dmg !== 4'd9) begin
      n_err++; $display("FAIL crit_off: got lat=%0d hit=%b crit=%b dmg=%0d expected 3/1/0/9",
                        lat, got.hit, got.crit, got.dmg);
    end
`endif
    ack(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_move3();
    test_back_to_back();
    test_random_move1();
    test_hold();
    test_reset_mid();
    test_crit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
